nor_bus_ctrl: RTL and testbench

- Second-generation parallel NOR flash controller with a pipelined Wishbone slave front end.
- Accepts a parametrised-depth queue of requests and drives the NOR pins with timing set entirely by parameters.
- Chains reads and page reads, with a parametrised page size.
- New over the previous generation: write completion is tracked via RY/BY# with a timeout that reports wb_err_o, and a cycle abort ends the NOR access cleanly.
- Sits between the bridge's Wishbone interconnect and the NOR pad ring.

---
 rtl/nor_bus_pkg.sv | 25 ++
 rtl/nor_req_fifo.sv | 59 +++++
 rtl/nor_bus_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_nor_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_bus_pkg.sv
// Shared types and helpers for the NOR flash bus controller.
package nor_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadDly,
        StRead,
        StReadPg,
        StRyWait,
        StTxnEnd
    } nor_state_e;

    // Width of one queued request packed as {we, dat, adr}.
    function automatic int unsigned req_bits(input int unsigned addr_bits,
                                             input int unsigned data_bits);
        return addr_bits + data_bits + 1;
    endfunction

    function automatic logic same_page(input logic [63:0] a, input logic [63:0] b,
                                       input int unsigned page_bits);
        return (a >> page_bits) == (b >> page_bits);
    endfunction

endpackage

// File: rtl/nor_req_fifo.sv
// Request queue; exposes the head and the entry behind it so reads can be chained.
module nor_req_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           next,
    output logic                       next_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q, rd_nxt;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign rd_nxt     = rd_ptr_q + PW'(1);
    assign head       = mem[rd_ptr_q];
    assign next       = mem[rd_nxt];
    assign head_valid = cnt_q != '0;
    assign next_valid = cnt_q >= (PW+1)'(2);
    assign full       = cnt_q == (PW+1)'(DEPTH);
    assign count      = cnt_q;

    assign do_pop  = pop && head_valid;
    // A pop frees the slot a push on a full queue needs in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_nxt;
            if (do_push && !do_pop)      cnt_q <= cnt_q + (PW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nor_bus_ctrl.sv
// Pipelined Wishbone slave driving a parallel NOR flash with parameterised timing.
module nor_bus_ctrl
    import nor_bus_pkg::*;
#(
    parameter int unsigned ADDRBITS   = 26,
    parameter int unsigned DATABITS   = 16,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned PAGEBITS   = 3,
    parameter int unsigned CNTBITS    = 10,
    parameter int unsigned T_WRITE    = 14,
    parameter int unsigned T_FIRST    = 28,
    parameter int unsigned T_READ     = 17,
    parameter int unsigned T_PAGE     = 7,
    parameter int unsigned T_END      = 1,
    parameter int unsigned RY_WAIT    = 1,
    parameter int unsigned RY_MIN     = 4,
    parameter int unsigned RY_TIMEOUT = 1000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [ADDRBITS-1:0] wb_adr_i,
    input  logic [DATABITS-1:0] wb_dat_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [DATABITS-1:0] wb_dat_o,
    output logic                wb_stall_o,
    input  logic                nor_ry_i,
    input  logic [DATABITS-1:0] nor_data_i,
    output logic [DATABITS-1:0] nor_data_o,
    output logic [ADDRBITS-1:0] nor_addr_o,
    output logic                nor_ce_o,
    output logic                nor_we_o,
    output logic                nor_oe_o,
    output logic                nor_data_oe
);
    localparam int unsigned REQBITS = req_bits(ADDRBITS, DATABITS);
    localparam int unsigned CW      = $clog2(QDEPTH) + 1;

    logic [REQBITS-1:0]  head, next;
    logic                head_valid, next_valid, fifo_full, push, pop, abort;
    logic [CW-1:0]       fifo_count;
    logic                head_we, next_we;
    logic [ADDRBITS-1:0] head_adr, next_adr;
    logic [DATABITS-1:0] head_dat;

    nor_state_e          state_q, state_d, chain_state;
    logic [CNTBITS-1:0]  cnt_q;
    logic                cnt_clr, ack_d, err_d, rd_done;
    logic                ry_meta_q, ry_sync_q;
    logic                ack_q, err_q, ce_q, we_q, oe_q, doe_q;
    logic [DATABITS-1:0] dat_q, data_q;
    logic [ADDRBITS-1:0] addr_q;

    assign head_we  = head[REQBITS-1];
    assign head_dat = head[ADDRBITS +: DATABITS];
    assign head_adr = head[ADDRBITS-1:0];
    assign next_we  = next[REQBITS-1];
    assign next_adr = next[ADDRBITS-1:0];

    assign abort      = !wb_cyc_i && (state_q != StIdle);
    assign push       = wb_cyc_i && wb_stb_i && !fifo_full;
    assign wb_stall_o = fifo_count == CW'(QDEPTH);

    nor_req_fifo #(
        .WIDTH (REQBITS),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .push       (push),
        .pop        (pop),
        .flush      (abort),
        .wdata      ({wb_we_i, wb_dat_i, wb_adr_i}),
        .head       (head),
        .head_valid (head_valid),
        .next       (next),
        .next_valid (next_valid),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    always_comb begin
        chain_state = StTxnEnd;
        if (next_valid && !next_we) begin
            chain_state = same_page(64'(head_adr), 64'(next_adr), PAGEBITS) ? StReadPg : StRead;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (head_valid) state_d = head_we ? StWrite : StReadDly;
            end
            StWrite: begin
                if (cnt_q == CNTBITS'(T_WRITE)) begin
                    if (RY_WAIT != 0) begin
                        state_d = StRyWait;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = StTxnEnd;
                    end
                end
            end
            StRyWait: begin
                if (cnt_q >= CNTBITS'(RY_MIN) && ry_sync_q) begin
                    ack_d   = 1'b1;
                    state_d = StTxnEnd;
                end else if (cnt_q == CNTBITS'(RY_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StTxnEnd;
                end
            end
            StReadDly: begin
                if (cnt_q == CNTBITS'(T_FIRST)) state_d = StRead;
            end
            StRead, StReadPg: begin
                if (cnt_q == ((state_q == StRead) ? CNTBITS'(T_READ) : CNTBITS'(T_PAGE))) begin
                    ack_d   = 1'b1;
                    rd_done = 1'b1;
                    state_d = chain_state;
                end
            end
            StTxnEnd: begin
                if (cnt_q == CNTBITS'(T_END)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort suppresses any completion this cycle; TXN_END just runs out normally.
        if (abort) begin
            ack_d   = 1'b0;
            err_d   = 1'b0;
            rd_done = 1'b0;
            if (state_q != StTxnEnd) state_d = StTxnEnd;
        end
    end

    assign pop = ack_d || err_d;
    // A chained page/random read re-enters its own state, so a pop restarts timing too.
    assign cnt_clr = (state_d != state_q) || pop;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ry_meta_q <= 1'b0;
            ry_sync_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            ce_q      <= 1'b1;
            we_q      <= 1'b1;
            oe_q      <= 1'b1;
            doe_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            if (cnt_clr)          cnt_q <= '0;
            else if (cnt_q != '1) cnt_q <= cnt_q + CNTBITS'(1);
            ry_meta_q <= nor_ry_i;
            ry_sync_q <= ry_meta_q;
            ack_q     <= ack_d;
            err_q     <= err_d;
            if (rd_done) dat_q <= nor_data_i;
            ce_q  <= abort || !(state_q inside {StWrite, StReadDly, StRead, StReadPg});
            we_q  <= abort || (state_q != StWrite);
            oe_q  <= abort || !(state_q inside {StReadDly, StRead, StReadPg});
            doe_q <= !abort && (state_q == StWrite);
            if (head_valid) begin
                addr_q <= head_adr;
                data_q <= head_dat;
            end
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = dat_q;
    assign nor_ce_o    = ce_q;
    assign nor_we_o    = we_q;
    assign nor_oe_o    = oe_q;
    assign nor_data_oe = doe_q;
    assign nor_addr_o  = addr_q;
    assign nor_data_o  = data_q;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Directed self-checking bench for nor_bus_ctrl with default timing parameters.
module tb_nor_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] wb_adr = '0;
    logic [15:0] wb_dat = '0;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
    logic        wb_ack, wb_err, wb_stall;
    logic [15:0] wb_dat_o;
    logic        nor_ry = 1'b1;
    logic [15:0] nor_din, nor_dout;
    logic [25:0] nor_addr;
    logic        nor_ce, nor_we, nor_oe, nor_doe;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    // Flash pad model: one fixed word at 0x10, otherwise derived from the address.
    assign nor_din = (nor_addr == 26'h10) ? 16'hA5A5 : {nor_addr[7:0] ^ 8'h3C, nor_addr[7:0]};

    nor_bus_ctrl u_dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat),
        .wb_we_i     (wb_we),
        .wb_stb_i    (wb_stb),
        .wb_cyc_i    (wb_cyc),
        .wb_ack_o    (wb_ack),
        .wb_err_o    (wb_err),
        .wb_dat_o    (wb_dat_o),
        .wb_stall_o  (wb_stall),
        .nor_ry_i    (nor_ry),
        .nor_data_i  (nor_din),
        .nor_data_o  (nor_dout),
        .nor_addr_o  (nor_addr),
        .nor_ce_o    (nor_ce),
        .nor_we_o    (nor_we),
        .nor_oe_o    (nor_oe),
        .nor_data_oe (nor_doe)
    );

    // Cycle counter and pin/response monitor, sampled on the falling edge.
    int          cyc_n = 0;
    int          ce_low = 0, oe_low = 0, we_low = 0, doe_cnt = 0, ce_fall = 0;
    int          ack_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
    logic        ce_prev = 1'b1;
    logic [15:0] ack_dat [64];
    int          ack_cyc [64];
    logic [15:0] wr_data_seen = '0;
    logic [25:0] wr_addr_seen = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!nor_ce) ce_low++;
            if (!nor_oe) oe_low++;
            if (!nor_we) begin
                we_low++;
                wr_data_seen = nor_dout;
                wr_addr_seen = nor_addr;
            end
            if (nor_doe) doe_cnt++;
            if (ce_prev && !nor_ce) ce_fall++;
            ce_prev = nor_ce;
            if (wb_ack && ack_cnt < 64) begin
                ack_dat[ack_cnt] = wb_dat_o;
                ack_cyc[ack_cnt] = cyc_n;
                ack_cnt++;
            end
            if (wb_err) begin
                err_cyc = cyc_n;
                err_cnt++;
            end
            if (wb_ack && wb_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns the cycle number of the accepting edge.
    task automatic send(input logic [25:0] adr, input logic [15:0] dat, input logic we,
                        output int acc);
        int guard = 0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = adr;
        wb_dat = dat;
        wb_we  = we;
        while (wb_stall && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        acc    = cyc_n;
        wb_stb = 1'b0;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int i = 0;
        while (ack_cnt < target && i < budget) begin
            tick();
            i++;
        end
    endtask

    int acc0, acc_tmp, b_ack, b_ce, b_oe, b_fall, b_we, b_doe, b_err;

    initial begin
        // Reset state
        #12;
        check("rst_ce", 32'(nor_ce), 32'd1);
        check("rst_we", 32'(nor_we), 32'd1);
        check("rst_oe", 32'(nor_oe), 32'd1);
        check("rst_doe", 32'(nor_doe), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_stall", 32'(wb_stall), 32'd0);
        check("rst_dat", 32'(wb_dat_o), 32'd0);
        check("rst_addr", 32'(nor_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single isolated read: 29 READDLY + 18 READ cycles, ack 48 after accept
        b_ack = ack_cnt; b_ce = ce_low; b_oe = oe_low; b_fall = ce_fall;
        send(26'h10, 16'h0, 1'b0, acc0);
        wait_acks(b_ack + 1, 200);
        repeat (6) tick();
        check("rd1_acks", 32'(ack_cnt - b_ack), 32'd1);
        check("rd1_data", 32'(ack_dat[b_ack]), 32'hA5A5);
        check("rd1_lat", 32'(ack_cyc[b_ack] - acc0), 32'd48);
        check("rd1_ce_low", 32'(ce_low - b_ce), 32'd47);
        check("rd1_oe_low", 32'(oe_low - b_oe), 32'd47);

        // Four reads in one page: READDLY, READ, then three 8-cycle READPG
        b_ack = ack_cnt; b_ce = ce_low; b_fall = ce_fall;
        send(26'h20, 16'h0, 1'b0, acc0);
        for (int i = 1; i < 4; i++) send(26'h20 + 26'(i), 16'h0, 1'b0, acc_tmp);
        wait_acks(b_ack + 4, 300);
        repeat (6) tick();
        check("pg_acks", 32'(ack_cnt - b_ack), 32'd4);
        check("pg_d0", 32'(ack_dat[b_ack]), 32'h1C20);
        check("pg_d1", 32'(ack_dat[b_ack+1]), 32'h1D21);
        check("pg_d2", 32'(ack_dat[b_ack+2]), 32'h1E22);
        check("pg_d3", 32'(ack_dat[b_ack+3]), 32'h1F23);
        check("pg_lat1", 32'(ack_cyc[b_ack+1] - acc0), 32'd56);
        check("pg_lat3", 32'(ack_cyc[b_ack+3] - acc0), 32'd72);
        check("pg_ce_low", 32'(ce_low - b_ce), 32'd71);
        check("pg_ce_fall", 32'(ce_fall - b_fall), 32'd1);

        // Page crossing 0x27 -> 0x28: second access is a random READ
        b_ack = ack_cnt; b_ce = ce_low; b_fall = ce_fall;
        send(26'h27, 16'h0, 1'b0, acc0);
        send(26'h28, 16'h0, 1'b0, acc_tmp);
        wait_acks(b_ack + 2, 300);
        repeat (6) tick();
        check("pc_acks", 32'(ack_cnt - b_ack), 32'd2);
        check("pc_d0", 32'(ack_dat[b_ack]), 32'h1B27);
        check("pc_d1", 32'(ack_dat[b_ack+1]), 32'h1428);
        check("pc_lat1", 32'(ack_cyc[b_ack+1] - acc0), 32'd66);
        check("pc_ce_low", 32'(ce_low - b_ce), 32'd65);
        check("pc_ce_fall", 32'(ce_fall - b_fall), 32'd1);

        // Write with RY low for 50 cycles after accept
        b_ack = ack_cnt; b_we = we_low; b_doe = doe_cnt; b_err = err_cnt;
        nor_ry = 1'b0;
        send(26'h40, 16'h1234, 1'b1, acc0);
        while (cyc_n < acc0 + 50) tick();
        nor_ry = 1'b1;
        wait_acks(b_ack + 1, 100);
        repeat (6) tick();
        check("wr_acks", 32'(ack_cnt - b_ack), 32'd1);
        check("wr_lat", 32'(ack_cyc[b_ack] - acc0), 32'd53);
        check("wr_we_low", 32'(we_low - b_we), 32'd15);
        check("wr_doe", 32'(doe_cnt - b_doe), 32'd15);
        check("wr_data", 32'(wr_data_seen), 32'h1234);
        check("wr_addr", 32'(wr_addr_seen), 32'h40);
        check("wr_no_err", 32'(err_cnt - b_err), 32'd0);

        // Write with RY stuck low: one err at the timeout, no ack, then a normal read
        b_ack = ack_cnt; b_err = err_cnt;
        nor_ry = 1'b0;
        send(26'h44, 16'h5678, 1'b1, acc0);
        for (int i = 0; i < 1100 && err_cnt == b_err; i++) tick();
        repeat (6) tick();
        nor_ry = 1'b1;
        check("to_errs", 32'(err_cnt - b_err), 32'd1);
        check("to_lat", 32'(err_cyc - acc0), 32'd1017);
        check("to_no_ack", 32'(ack_cnt - b_ack), 32'd0);
        send(26'h10, 16'h0, 1'b0, acc0);
        wait_acks(b_ack + 1, 200);
        check("to_rd_acks", 32'(ack_cnt - b_ack), 32'd1);
        check("to_rd_data", 32'(ack_dat[b_ack]), 32'hA5A5);
        check("to_rd_lat", 32'(ack_cyc[b_ack] - acc0), 32'd48);
        repeat (6) tick();

        // QDEPTH+1 back-to-back strobes, then abort mid read
        b_ack = ack_cnt;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_adr = 26'h100 + 26'(i);
            if (i == 3) begin
                @(negedge clk);
                check("q_stall_3", 32'(wb_stall), 32'd0);
            end
            tick();
        end
        wb_adr = 26'h104;
        @(negedge clk);
        check("q_stall_4", 32'(wb_stall), 32'd1);
        tick();
        wb_stb = 1'b0;
        wait_acks(b_ack + 1, 200);
        check("q_ack0", 32'(ack_dat[b_ack]), 32'h3C00);
        repeat (3) tick();
        wb_cyc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ab_ce_high", 32'(nor_ce), 32'd1);
        check("ab_oe_high", 32'(nor_oe), 32'd1);
        check("ab_flushed", 32'(wb_stall), 32'd0);
        repeat (100) tick();
        check("ab_no_ack", 32'(ack_cnt - b_ack), 32'd1);

        // Asynchronous reset in the middle of a write
        b_ack = ack_cnt;
        send(26'h80, 16'hBEEF, 1'b1, acc0);
        repeat (6) tick();
        @(negedge clk);
        check("rw_we_low", 32'(nor_we), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_we", 32'(nor_we), 32'd1);
        check("rw_ce", 32'(nor_ce), 32'd1);
        check("rw_doe", 32'(nor_doe), 32'd0);
        wb_cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("rw_no_ack", 32'(ack_cnt - b_ack), 32'd0);

        check("ack_err_excl", 32'(both_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
